// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and types for the fetch/decode front end
package cpu_pkg;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0100_0000;
  localparam logic [6:0] OPC_JAL = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;
  typedef enum logic {RUN, DRAIN} fetch_state_t;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: synchronous FIFO of DEPTH entries of type T (power-of-2 depth)
//   in : clk, reset_n (sync, active-low), push/wr_data, pop, flush
//   out: empty, count (occupancy), head (oldest entry, combinational)
module fetch_buffer
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter type T = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  T                       wr_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output T                       head
);
  localparam int AW = $clog2(DEPTH);
  T mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_pop;
  always_comb begin
    do_pop = pop && cnt_q != '0;
    rd_d = flush ? '0 : rd_q + AW'(do_pop);
    wr_d = flush ? '0 : wr_q + AW'(push);
    cnt_d = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
    if (push && !flush) mem_q[wr_q] <= wr_data;
  end
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign head = mem_q[rd_q];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with PC, imem request channel, buffer and redirect drain
//   in : clk, reset_n (sync, active-low), stall, redirect/redirect_pc,
//        imem_req_ready, imem_rsp_valid/imem_rsp_data
//   out: imem_req_valid/imem_req_addr, inst_f, PC_f, valid_f
//   FETCH_PERF_CNT_EN adds perf_fetched, perf_dropped, perf_stall counters
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] inst_f,
  output logic [31:0] PC_f,
  output logic        valid_f
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_dropped,
  output logic [31:0] perf_stall
`endif
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  fetch_state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, tag_head;
  logic [CW-1:0] drop_q, drop_d, buf_cnt, tag_cnt;
  logic buf_empty, tag_empty, issue, rsp_ok, buf_push, buf_pop;
  fetch_entry_t buf_head, buf_in;
  always_comb begin
    rsp_ok = imem_rsp_valid && !tag_empty;
    issue = imem_req_valid && imem_req_ready;
    buf_push = rsp_ok && state_q == RUN && !redirect;
    buf_pop = valid_f && !stall && !redirect;
    buf_in = '{pc: tag_head, inst: imem_rsp_data};
  end
  // tag queue holds the PC of every outstanding request; its count is the in-flight count
  fetch_buffer #(.DEPTH(BUF_DEPTH), .T(logic [31:0])) u_tag (
    .clk(clk), .reset_n(reset_n), .push(issue), .wr_data(pc_q), .pop(rsp_ok),
    .flush(1'b0), .empty(tag_empty), .count(tag_cnt), .head(tag_head)
  );
  fetch_buffer #(.DEPTH(BUF_DEPTH), .T(fetch_entry_t)) u_buf (
    .clk(clk), .reset_n(reset_n), .push(buf_push), .wr_data(buf_in), .pop(buf_pop),
    .flush(redirect), .empty(buf_empty), .count(buf_cnt), .head(buf_head)
  );
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= RUN;
      pc_q <= RESET_PC;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      drop_q <= drop_d;
    end
  end
  // a response arriving in the redirect cycle is already counted out of drop_d
  always_comb begin
    pc_d = redirect ? (redirect_pc & ~32'h3) : pc_q + (issue ? 32'd4 : 32'd0);
    drop_d = state_q == DRAIN ? drop_q - CW'(rsp_ok) : redirect ? tag_cnt - CW'(rsp_ok) : '0;
    state_d = drop_d != '0 ? DRAIN : RUN;
  end
  always_comb begin
    imem_req_valid = reset_n && state_q == RUN && !redirect &&
                     ({1'b0, buf_cnt} + {1'b0, tag_cnt} < (CW+1)'(BUF_DEPTH));
    imem_req_addr = pc_q;
    valid_f = !buf_empty;
    inst_f = buf_empty ? NOP_INST : buf_head.inst;
    PC_f = buf_empty ? '0 : buf_head.pc;
  end
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d, perf_dropped_q, perf_dropped_d, perf_stall_q, perf_stall_d;
  always_comb begin
    perf_fetched_d = perf_fetched_q + 32'(buf_pop);
    perf_dropped_d = perf_dropped_q + (redirect ? 32'(buf_cnt) : 32'd0) + 32'(rsp_ok && !buf_push);
    perf_stall_d = perf_stall_q + 32'(stall && valid_f);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_dropped_q <= perf_dropped_d;
      perf_stall_q <= perf_stall_d;
    end
  end
  assign perf_fetched = perf_fetched_q;
  assign perf_dropped = perf_dropped_q;
  assign perf_stall = perf_stall_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed tables plus randomized traffic against a queue-based fetch model
module tb_fetch_unit;
  localparam int DEPTH = 2;
  localparam logic [31:0] RPC = 32'h0100_0000;
  logic clk = 0, reset_n = 0, stall = 0, redirect = 0, imem_req_ready = 0, imem_rsp_valid = 0;
  logic [31:0] redirect_pc = '0, imem_rsp_data = '0;
  logic imem_req_valid, valid_f;
  logic [31:0] imem_req_addr, inst_f, PC_f;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_dropped, perf_stall;
`endif
  always #5 clk = ~clk;
  fetch_unit #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_f(inst_f), .PC_f(PC_f), .valid_f(valid_f)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_dropped(perf_dropped), .perf_stall(perf_stall)
`endif
  );
  typedef struct {logic [31:0] pc; bit stale;} tag_t;
  typedef struct {logic [31:0] pc; logic [31:0] inst;} ent_t;
  typedef struct {logic [31:0] a; int due;} req_t;
  typedef struct {logic [31:0] rpc; logic [31:0] addr;} vec_t;
  tag_t m_infl[$];
  ent_t m_buf[$];
  req_t imq[$];
  logic [31:0] m_pc, m_fetched, m_dropped, m_stall;
  int cyc, checks = 0, failures = 0, lat_min = 1, lat_max = 1;
  bit rsp_always = 1;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_3C3C;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic do_reset;
    @(negedge clk);
    reset_n = 0; stall = 0; redirect = 0; redirect_pc = '0; imem_req_ready = 0; imem_rsp_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 0);
    chk("rst_valid_f", 32'(valid_f), 0);
    chk("rst_inst_f", inst_f, 32'h13);
    chk("rst_PC_f", PC_f, 0);
    m_infl.delete(); m_buf.delete(); imq.delete();
    m_pc = RPC; m_fetched = 0; m_dropped = 0; m_stall = 0; cyc = 0;
  endtask
  // one clock: drive inputs, compare against the model, advance model and imem; returns just after the edge
  task automatic cycle(input logic s, input logic r, input logic [31:0] rp, input logic rd);
    bit drain, rv;
    tag_t t;
    logic [31:0] a;
    @(negedge clk);
    reset_n = 1; stall = s; redirect = r; redirect_pc = rp; imem_req_ready = rd;
    imem_rsp_valid = imq.size() > 0 && imq[0].due <= cyc && (rsp_always || $urandom_range(0, 3) != 0);
    imem_rsp_data = imem_rsp_valid ? mem_word(imq[0].a) : $urandom;
    #1;
    drain = 0;
    foreach (m_infl[i]) if (m_infl[i].stale) drain = 1;
    rv = !drain && !r && (m_buf.size() + m_infl.size() < DEPTH);
    chk("req_valid", 32'(imem_req_valid), 32'(rv));
    chk("req_addr", imem_req_addr, m_pc);
    chk("valid_f", 32'(valid_f), 32'(m_buf.size() > 0));
    chk("inst_f", inst_f, m_buf.size() > 0 ? m_buf[0].inst : 32'h13);
    chk("PC_f", PC_f, m_buf.size() > 0 ? m_buf[0].pc : 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, m_fetched);
    chk("perf_dropped", perf_dropped, m_dropped);
    chk("perf_stall", perf_stall, m_stall);
`endif
    a = m_pc;
    if (s && m_buf.size() > 0) m_stall++;
    if (!r && !s && m_buf.size() > 0) begin
      void'(m_buf.pop_front());
      m_fetched++;
    end
    if (imem_rsp_valid) begin
      t = m_infl.pop_front();
      if (t.stale || r) m_dropped++;
      else m_buf.push_back('{t.pc, imem_rsp_data});
      void'(imq.pop_front());
    end
    if (r) begin
      m_dropped += 32'(m_buf.size());
      m_buf.delete();
      foreach (m_infl[i]) m_infl[i].stale = 1;
      m_pc = rp & ~32'h3;
    end else if (rv && rd) begin
      m_infl.push_back('{a, 0});
      imq.push_back('{a, cyc + $urandom_range(lat_min, lat_max)});
      m_pc = m_pc + 32'd4;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end
  initial begin
    vec_t vecs[5];
    bit found;
    vecs[0] = '{32'h0000_0007, 32'h0000_0004};
    vecs[1] = '{32'h0100_0040, 32'h0100_0040};
    vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC};
    vecs[3] = '{32'h0000_0002, 32'h0000_0000};
    vecs[4] = '{32'h1234_5679, 32'h1234_5678};
    // streaming fetch, 1-cycle imem
    do_reset();
    cycle(0, 0, 0, 1);
    chk("t1_c0_valid_f", 32'(valid_f), 0);
    cycle(0, 0, 0, 1);
    chk("t1_c1_valid_f", 32'(valid_f), 1);
    chk("t1_c1_PC_f", PC_f, 32'h0100_0000);
    chk("t1_c1_inst_f", inst_f, mem_word(32'h0100_0000));
    repeat (6) cycle(0, 0, 0, 1);
    // stall with a full buffer
    do_reset();
    repeat (8) cycle(1, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 0, 1);
      chk("t2_hold_PC_f", PC_f, 32'h0100_0000);
      chk("t2_hold_req_valid", 32'(imem_req_valid), 0);
    end
    cycle(0, 0, 0, 1);
    chk("t2_next_valid_f", 32'(valid_f), 1);
    chk("t2_next_PC_f", PC_f, 32'h0100_0004);
    repeat (4) cycle(0, 0, 0, 1);
    // redirect with two requests in flight
    do_reset();
    lat_min = 3; lat_max = 3;
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    cycle(0, 1, 32'h0100_0040, 1);
    chk("t3_flush_valid_f", 32'(valid_f), 0);
    cycle(0, 0, 0, 1);
    chk("t3_drain_req_valid", 32'(imem_req_valid), 0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(0, 0, 0, 1);
      found = valid_f;
    end
    chk("t3_valid_seen", 32'(found), 1);
    chk("t3_PC_f", PC_f, 32'h0100_0040);
`ifdef FETCH_PERF_CNT_EN
    chk("t3_perf_dropped", perf_dropped, 2);
`endif
    // redirect coinciding with a response while stalled
    do_reset();
    lat_min = 1; lat_max = 1;
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 1);
    cycle(1, 1, 32'h0100_0080, 1);
    chk("t4_valid_f", 32'(valid_f), 0);
    chk("t4_inst_f", inst_f, 32'h13);
    chk("t4_PC_f", PC_f, 0);
`ifdef FETCH_PERF_CNT_EN
    chk("t4_perf_dropped", perf_dropped, 2);
`endif
    repeat (4) cycle(0, 0, 0, 1);
    // redirect target alignment
    do_reset();
    foreach (vecs[i]) begin
      cycle(0, 1, vecs[i].rpc, 0);
      chk("t5_align_addr", imem_req_addr, vecs[i].addr);
    end
    // PC wrap at the top of the address space
    cycle(0, 1, 32'hFFFF_FFFC, 0);
    cycle(0, 0, 0, 1);
    chk("t6_wrap_addr", imem_req_addr, 32'h0000_0000);
    repeat (4) cycle(0, 0, 0, 1);
    // randomized traffic
    do_reset();
    lat_min = 1; lat_max = 4; rsp_always = 0;
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 9) < 7);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that produces `inst_f` and `PC_f` for the fetch/decode pipeline register.
- Owns the program counter and issues word requests to instruction memory over a valid/ready request channel with a separate response channel.
- Holds returned instructions in a small buffer, presents them in order, and holds on `stall`.
- On `redirect` from execute, flushes the buffer and discards stale in-flight responses.

Parameters:
- RESET_PC, 32'h0100_0000, PC of the first fetch after reset.
- BUF_DEPTH, 2, instruction buffer entries; also the maximum number of outstanding imem requests (power of 2, ≥2).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- stall  in  1  decode cannot accept; hold the presented instruction
- redirect  in  1  control-flow change from execute
- redirect_pc  in  32  new fetch PC, valid with `redirect`
- imem_req_valid  out  1  request present
- imem_req_ready  in  1  imem accepts request
- imem_req_addr  out  32  word-aligned fetch address
- imem_rsp_valid  in  1  response data valid; in request order, ≥1 cycle after acceptance
- imem_rsp_data  in  32  instruction word
- inst_f  out  32  instruction to decode
- PC_f  out  32  PC of `inst_f`
- valid_f  out  1  `inst_f`/`PC_f` hold a real instruction

Behaviour:
- Reset (`reset_n`=0 at a clk edge):
  - `pc_next`=RESET_PC, buffer empty, in-flight=0, drop_cnt=0, state RUN.
  - `imem_req_valid`=0, `valid_f`=0, `inst_f`=32'h13, `PC_f`=0.
  - imem shares the reset, so no pre-reset response arrives afterwards.
- Request issue (RUN only):
  - `imem_req_valid`=1 when (buffer occupancy + in-flight) < BUF_DEPTH and `redirect`=0.
  - `imem_req_addr`=`pc_next`.
  - On handshake: in-flight+1; `pc_next`+=4, wrapping 32'hFFFF_FFFC→0; the issued PC is pushed into the PC tag queue.
  - Max throughput is one request per cycle.
- Response:
  - In RUN, `imem_rsp_valid` pushes {tag PC, data} into the buffer; in-flight−1.
  - The buffer can never overflow, guaranteed by the issue rule.
- Output:
  - When the buffer is non-empty: `valid_f`=1 and `inst_f`/`PC_f` come from the buffer head, combinationally.
  - When the buffer is empty: `valid_f`=0, `inst_f`=32'h13, `PC_f`=0.
  - Head pops when `valid_f`=1 and `stall`=0.
  - Response-to-`valid_f` latency with an empty buffer: 1 cycle after `imem_rsp_valid`.
- Simultaneous push and pop is allowed at any occupancy.
- Redirect (priority over `stall` and all other events):
  - Buffer flushed; `valid_f`=0 next cycle.
  - `pc_next`=`redirect_pc` & ~3.
  - drop_cnt = in-flight after this cycle's issue/response accounting, i.e. a response arriving in the redirect cycle is discarded. No request is issued that cycle.
  - If drop_cnt>0 go to DRAIN, else stay in RUN.
- States:
  - RUN: normal operation.
  - DRAIN: no requests; each `imem_rsp_valid` decrements drop_cnt and in-flight, and its data is discarded.
  - DRAIN→RUN in the cycle drop_cnt reaches 0; issue resumes the next cycle.
  - Redirect while in DRAIN updates `pc_next` only; drop_cnt is unchanged.
- `stall` with an empty buffer has no effect. Fetch continues until the buffer fills, then `imem_req_valid`=0.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs `perf_fetched`[31:0] (buffer pops), `perf_dropped`[31:0] (discarded responses plus flushed buffer entries) and `perf_stall`[31:0] (cycles with `stall`=1 and `valid_f`=1).
  - All three reset to 0 and wrap at 2^32.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package `cpu_pkg`:
  - NOP_INST=32'h13
  - DEFAULT_RESET_PC=32'h0100_0000
  - opcode localparams (JAL, JALR, BRANCH)
  - typedef fetch_entry_t {pc[31:0], inst[31:0]}
- Sub-module `fetch_buffer`:
  - Synchronous FIFO of fetch_entry_t, depth BUF_DEPTH.
  - Ports: push, pop, flush, empty, count, head.
  - Also instantiated for the PC tag queue.

Test Plan:
- Reset, imem 1-cycle latency, `stall`=0 → requests at 0x0100_0000, 0x0100_0004, …; first `valid_f`=1 with `PC_f`=0x0100_0000 two cycles after reset release.
- `stall` held 5 cycles with buffer full (2 entries) → `inst_f`/`PC_f` constant, `imem_req_valid`=0; after release, entries are presented in order with no gaps.
- `redirect` to 0x0100_0040 with 2 responses in flight → both responses discarded (DRAIN), next `valid_f` has `PC_f`=0x0100_0040; `perf_dropped`=2 with FETCH_PERF_CNT_EN.
- `redirect` and `imem_rsp_valid` in the same cycle with `stall`=1 → response dropped, buffer empty next cycle, `inst_f`=0x13.
- `redirect_pc`=0x0000_0007 → `imem_req_addr`=0x0000_0004.
- `pc_next`=0xFFFF_FFFC accepted → next request address 0x0000_0000.
